// File: rtl/gpr_sched_pkg.sv
// Shared defaults, typedefs and grant-source encoding for the GPR write-back scheduler.
package gpr_sched_pkg;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

   typedef logic [AW_DEF-1:0] reg_idx_t;
   typedef logic [DW_DEF-1:0] word_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_SKID = 2'd2,
      GNT_B    = 2'd3
   } gnt_src_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard for long-latency destinations; flags RAW/WAW hazards at issue.
module gpr_scoreboard
   import gpr_sched_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rs,
   input  logic [AW-1:0] issue_rt,
   input  logic [AW-1:0] issue_rd,
   input  logic          issue_long,
   input  logic          stall,
   input  logic          clr_valid,
   input  logic [AW-1:0] clr_idx,
   output logic          hazard
);

   localparam int NREG = 1 << AW;

   logic [NREG-1:0] pending;
   logic            set_valid;

   assign set_valid = issue_valid && !stall && issue_long && (issue_rd != '0);
   assign hazard    = issue_valid && (pending[issue_rs] || pending[issue_rt] || pending[issue_rd]);

   // The set is written after the clear so a same-index collision leaves the bit set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         if (clr_valid) pending[clr_idx] <= 1'b0;
         if (set_valid) pending[issue_rd] <= 1'b1;
      end
   end

endmodule

// File: rtl/gpr_wb_sched.sv
// Arbitrates the single GPR write port between pipeline write-back (A) and the long unit (B).
// Optional trace output is enabled by defining GPR_SCHED_TRACE_EN.
module gpr_wb_sched
   import gpr_sched_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rs,
   input  logic [AW-1:0] issue_rt,
   input  logic [AW-1:0] issue_rd,
   input  logic          issue_long,
   output logic          stall,
   input  logic          a_valid,
   input  logic [AW-1:0] a_rd,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   input  logic [AW-1:0] b_rd,
   input  logic [DW-1:0] b_data,
   output logic          b_ready,
   output logic          gpr_we,
   output logic [AW-1:0] gpr_wsel,
   output logic [DW-1:0] gpr_wdata
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   gnt_src_t      gnt;
   logic          capture_a;
   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;
   logic          skid_full;
   logic [AW-1:0] skid_rd;
   logic [DW-1:0] skid_data;
   logic [WCW-1:0] wait_cnt;
   logic          hazard;

   // Starved B outranks the pipeline; A cannot wait, so it parks in the skid instead.
   always_comb begin
      gnt       = GNT_NONE;
      capture_a = 1'b0;
      if (b_valid && (wait_cnt == WCW'(MAX_WAIT)) && !skid_full) begin
         gnt       = GNT_B;
         capture_a = a_valid;
      end else if (skid_full) begin
         gnt       = GNT_SKID;
         capture_a = a_valid;
      end else if (a_valid) begin
         gnt = GNT_A;
      end else if (b_valid) begin
         gnt = GNT_B;
      end
   end

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      case (gnt)
         GNT_A:    begin sel_rd = a_rd;    sel_data = a_data;    end
         GNT_SKID: begin sel_rd = skid_rd; sel_data = skid_data; end
         GNT_B:    begin sel_rd = b_rd;    sel_data = b_data;    end
         default:  begin sel_rd = '0;      sel_data = '0;        end
      endcase
   end

   assign b_ready = (gnt == GNT_B);
   assign stall   = hazard || skid_full;

   // Writes to R0 are consumed but never reach the register file.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gpr_we    <= 1'b0;
         gpr_wsel  <= '0;
         gpr_wdata <= '0;
         skid_full <= 1'b0;
         skid_rd   <= '0;
         skid_data <= '0;
         wait_cnt  <= '0;
      end else begin
         gpr_we <= (gnt != GNT_NONE) && (sel_rd != '0);
         if (gnt != GNT_NONE) begin
            gpr_wsel  <= sel_rd;
            gpr_wdata <= sel_data;
         end
         if (capture_a) begin
            skid_full <= 1'b1;
            skid_rd   <= a_rd;
            skid_data <= a_data;
         end else if (gnt == GNT_SKID) begin
            skid_full <= 1'b0;
         end
         if (!b_valid || b_ready)
            wait_cnt <= '0;
         else if (!skid_full && (wait_cnt != WCW'(MAX_WAIT)))
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   gpr_scoreboard #(.AW(AW)) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_rs    (issue_rs),
      .issue_rt    (issue_rt),
      .issue_rd    (issue_rd),
      .issue_long  (issue_long),
      .stall       (stall),
      .clr_valid   (b_valid && b_ready),
      .clr_idx     (b_rd),
      .hazard      (hazard)
   );

`ifdef GPR_SCHED_TRACE_EN
   gnt_src_t src_q;
   logic     stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_q   <= GNT_NONE;
         stall_q <= 1'b0;
      end else begin
         src_q   <= gnt;
         stall_q <= stall;
      end
   end

   always @(posedge clk) begin
      if (rst_n && gpr_we)
         $display("WB[%s] R[%02d]=%08h",
                  (src_q == GNT_A) ? "A" : (src_q == GNT_SKID) ? "SKID" : "B",
                  gpr_wsel, gpr_wdata);
      if (rst_n && stall && !stall_q)
         $display("STALL pending=%h", u_sb.pending);
   end
`endif

endmodule
